// File: rtl/arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_mux                                                         |
// | Purpose  : Registered N-way valid/ready mux, fixed-select or round-robin.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   slct,
  input  logic               rr_en,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_src
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load_en;
  logic [SEL_W-1:0] w_hi_idx;
  logic             w_hi_found;
  logic [SEL_W-1:0] w_lo_idx;
  logic             w_fix_valid;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_valid;
  logic [WIDTH-1:0] w_sel_data;
  logic [SEL_W-1:0] w_ptr_next;

  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin: lowest valid index at or above ptr, else lowest valid overall (wrap).
  always_comb begin
    w_hi_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && (SEL_W'(i) >= r_ptr)) begin
        w_hi_idx   = SEL_W'(i);
        w_hi_found = 1'b1;
      end
      if (in_valid[i]) begin
        w_lo_idx = SEL_W'(i);
      end
    end
  end

  // Fixed select: an out-of-range slct matches no channel and yields no grant.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (slct == SEL_W'(i)) begin
        w_fix_valid = in_valid[i];
      end
    end
  end

  always_comb begin
    if (rr_en) begin
      w_grant       = w_hi_found ? w_hi_idx : w_lo_idx;
      w_grant_valid = |in_valid;
    end else begin
      w_grant       = slct;
      w_grant_valid = w_fix_valid;
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + SEL_W'(1);

  generate
    for (genvar g = 0; g < N; g++) begin : g_ready
      assign in_ready[g] = !rst && w_load_en && w_grant_valid && (w_grant == SEL_W'(g));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_out_data <= w_sel_data;
        r_out_src  <= w_grant;
        r_ptr      <= w_ptr_next;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/arb_mux.md
# arb_mux

Registered N-way datapath multiplexer with valid/ready handshakes on every input channel and on the output. It is a generalised successor to the fixed 4-input select mux: channel count and width are parameters, and it supports two modes, fixed-select and round-robin arbitration. It sits between multiple producers (e.g. writeback/forwarding sources, memory request ports) and a single consumer stage, adding one register stage.

## Interface
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N >= 1)
- SEL_W, 2, select/index width; N <= 2**SEL_W
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  flattened inputs; channel i = in_data[i*WIDTH +: WIDTH]
- in_valid  input  N  channel i has data
- in_ready  output  N  channel i accepted this cycle (combinational)
- slct  input  SEL_W  channel index used when rr_en=0
- rr_en  input  1  0 = fixed select, 1 = round-robin
- out_data  output  WIDTH  registered output data
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_src  output  SEL_W  index of channel that produced out_data

## Operation
- State: output register (out_data, out_src, out_valid) and round-robin pointer ptr[SEL_W-1:0].
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0; in_ready is all 0 while rst=1.
- load_en = !out_valid || out_ready.
- Fixed mode (rr_en=0): grant = slct, and the grant is valid iff slct < N and in_valid[slct]. If slct >= N, there is no grant and no channel is accepted.
- RR mode (rr_en=1): grant = first i with in_valid[i], scanning ptr, ptr+1, ..., wrapping modulo N. The grant is valid iff any in_valid bit is set.
- in_ready[i] = !rst && load_en && grant_valid && (grant == i). At most one bit is ever set.
- Transfer when load_en:
  - With a grant: out_data <= selected channel's data, out_src <= grant, out_valid <= 1, ptr <= (grant+1) mod N.
  - With no grant: out_valid <= 0 and out_data/out_src hold.
- ptr advances on every accepted transfer in either mode. Switching modes therefore preserves fairness from the last granted channel.
- Stall (out_valid && !out_ready): out_data, out_src, out_valid and ptr hold, and in_ready is all 0.
- rr_en and slct are sampled combinationally each cycle. A change takes effect for the same-cycle grant.
- N=1: the block degenerates to a one-deep pipeline register, with ptr fixed at 0.

## Timing
- Latency: data accepted in cycle t (in_ready[i]=1) appears on out_data with out_valid=1 in cycle t+1.
- Throughput: one transfer per cycle when out_ready is held high. The consumer accepting and a new load occur in the same cycle with no bubble.
- in_ready depends combinationally on in_valid, slct, rr_en, out_valid and out_ready. It has no dependency on in_data.
- Reset mid-operation: a pending out_valid word is dropped; the next cycle after rst deasserts behaves as from power-on with ptr=0.
- Producers must hold in_data/in_valid stable until in_ready is seen. The block never drops an accepted word.

## Test plan
- Reset: rst=1 for 2 cycles with all in_valid=1 and out_ready=1 -> in_ready=0000, out_valid=0, out_data=0, out_src=0 throughout; first grant occurs in the cycle rst falls.
- Fixed select (WIDTH=4, N=4): inputs 2,4,6,8 all valid, rr_en=0, out_ready=1, slct stepped 0,1,2,3 one per cycle -> out_data 0010,0100,0110,1000 with out_src 0,1,2,3, each one cycle after its select.
- Round-robin fairness: all valid, rr_en=1, out_ready=1 from reset -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, with in_ready one-hot rotating.
- Sparse wrap: rr_en=1, in_valid=1010 -> out_src 1,3,1,3. Then set in_valid=0001 after a grant to 3 -> next out_src=0 (pointer wraps).
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_src hold, in_ready=0000, ptr unchanged. When out_ready returns to 1, the next channel is accepted that cycle and appears one cycle later.
- Boundaries with N=3, SEL_W=2:
  - rr_en=0, slct=3 -> in_ready=000 and out_valid drops to 0 after the current word drains.
  - rst pulse mid-stream -> out_valid=0 next cycle and the RR order restarts at channel 0.
